// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM rectangle-fill engine.
//   - Screen geometry and the VRAM word-address base.
//   - FSM state encoding, kept as plain localparam constants.
//   - Latched fill-command record.
//   - Pixel (x, y) to 30-bit word-address helper.
package vram_pkg;

  localparam int          SCREEN_W  = 320;
  localparam int          SCREEN_H  = 240;
  localparam logic [13:0] VRAM_BASE = 14'h0001;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] RD     = 3'd2;
  localparam logic [2:0] RWAIT  = 3'd3;
  localparam logic [2:0] WR     = 3'd4;
  localparam logic [2:0] NEXT   = 3'd5;
  localparam logic [2:0] FINISH = 3'd6;

  typedef struct packed {
    logic [8:0] x0;
    logic [8:0] y0;
    logic [8:0] w;
    logic [8:0] h;
    logic [3:0] color;
  } fill_cmd_t;

  // Four 4-bit pixels share one word, so the word index is the pixel index / 4.
  function automatic logic [29:0] word_addr(input logic [8:0] x, input logic [8:0] y);
    logic [17:0] p;
    p = 18'(y) * 18'(SCREEN_W) + 18'(x);
    return {VRAM_BASE, p[17:2]};
  endfunction

endpackage

// File: rtl/vram_fill_engine_if.sv
// RAM port-A master bus used by the fill engine.
//   req   : access request (master)
//   gnt   : grant; access happens in a cycle with req and gnt both high
//   addr  : 30-bit word address
//   wren  : 1 = write, 0 = read (valid while req is high)
//   wdata : write data
//   rdata : read data, valid exactly one cycle after a granted read
interface vram_fill_engine_if;
  logic        req;
  logic        gnt;
  logic [29:0] addr;
  logic        wren;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output req, addr, wren, wdata, input gnt, rdata);
  modport slave  (input req, addr, wren, wdata, output gnt, rdata);
endinterface

// File: rtl/vram_nibble_merge.sv
// Combinational nibble mask and merge for one VRAM word.
//   cx_lo     : nibble position of the first pixel to fill in this word
//   remaining : pixels left in the row from that position (xe - cx)
//   color     : fill colour
//   rdata     : current word contents (only [15:0] carry pixels)
//   mask      : nibbles of this word that the fill covers
//   merged    : rdata[15:0] with masked nibbles replaced, [31:16] zero
module vram_nibble_merge (
  input  logic [1:0]  cx_lo,
  input  logic [9:0]  remaining,
  input  logic [3:0]  color,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] merged
);

  // The upper half of the word holds no pixels.
  logic unused_rdata_hi;
  assign unused_rdata_hi = ^rdata[31:16];

  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
    mask   = '0;
    merged = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(cx_lo) && (i - int'(cx_lo)) < int'(remaining))
        mask[i] = 1'b1;
      merged[4*i +: 4] = mask[i] ? color : rdata[4*i +: 4];
    end
  end

endmodule

// File: rtl/vram_fill_engine.sv
// Rectangle-fill write master for the 4-bpp VGA VRAM region.
//   clk, reset_n     : clock, asynchronous active-low reset
//   start            : command strobe, accepted only in IDLE
//   x0, y0, w, h     : rectangle origin and size (clipped to the screen)
//   color            : fill colour
//   busy             : command in progress
//   done             : one-cycle completion pulse
//   mem              : RAM port-A master (request/grant)
// Walks the rectangle row by row one word at a time. Words covered fully
// are written directly; partial words are read, merged and written back.
module vram_fill_engine
  import vram_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [8:0] x0,
  input  logic [8:0] y0,
  input  logic [8:0] w,
  input  logic [8:0] h,
  input  logic [3:0] color,
  output logic       busy,
  output logic       done,
  vram_fill_engine_if.master mem
);

  logic [2:0]  state;
  fill_cmd_t   cmd;
  logic [8:0]  cx, cy;
  logic        req_q, wren_q;
  logic [29:0] addr_q;
  logic [31:0] wdata_q;

  logic [9:0]  xe_raw, ye_raw, xe, ye;
  logic        empty_cmd;
  logic [8:0]  step_cx, walk_cx, walk_cy, sel_cx, sel_cy;
  logic        row_end, last_row;
  logic [9:0]  remaining;
  logic [3:0]  mask;
  logic [31:0] merged;
  logic        full_word;

  // Clip the rectangle to the screen and derive the walk position.
  // In NEXT the mask/address are evaluated for the upcoming word so the
  // next access can be issued without an extra cycle.
  always_comb begin
    xe_raw    = {1'b0, cmd.x0} + {1'b0, cmd.w};
    ye_raw    = {1'b0, cmd.y0} + {1'b0, cmd.h};
    xe        = (xe_raw > 10'(SCREEN_W)) ? 10'(SCREEN_W) : xe_raw;
    ye        = (ye_raw > 10'(SCREEN_H)) ? 10'(SCREEN_H) : ye_raw;
    empty_cmd = (xe <= {1'b0, cmd.x0}) || (ye <= {1'b0, cmd.y0});

    step_cx   = {cx[8:2] + 7'd1, 2'b00};
    row_end   = {1'b0, step_cx} >= xe;
    walk_cx   = row_end ? cmd.x0 : step_cx;
    walk_cy   = row_end ? cy + 9'd1 : cy;
    last_row  = {1'b0, walk_cy} >= ye;

    sel_cx    = (state == NEXT) ? walk_cx : cx;
    sel_cy    = (state == NEXT) ? walk_cy : cy;
    remaining = xe - {1'b0, sel_cx};
    full_word = (mask == 4'hF);
  end

  vram_nibble_merge u_merge (
    .cx_lo     (sel_cx[1:0]),
    .remaining (remaining),
    .color     (cmd.color),
    .rdata     (mem.rdata),
    .mask      (mask),
    .merged    (merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cmd     <= '0;
      cx      <= '0;
      cy      <= '0;
      req_q   <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (start) begin
            cmd.x0    <= x0;
            cmd.y0    <= y0;
            cmd.w     <= w;
            cmd.h     <= h;
            cmd.color <= color;
            cx        <= x0;
            cy        <= y0;
            state     <= SETUP;
          end
        end

        SETUP, NEXT: begin
          if ((state == SETUP) ? empty_cmd : last_row) begin
            state <= FINISH;
          end else begin
            cx     <= sel_cx;
            cy     <= sel_cy;
            addr_q <= word_addr(sel_cx, sel_cy);
            req_q  <= 1'b1;
            wren_q <= full_word;
            // A full mask replaces every pixel nibble, so rdata is irrelevant here.
            if (full_word) wdata_q <= merged;
            state  <= full_word ? WR : RD;
          end
        end

        RD: begin
          if (mem.gnt) begin
            req_q <= 1'b0;
            state <= RWAIT;
          end
        end

        RWAIT: begin
          wdata_q <= merged;
          wren_q  <= 1'b1;
          req_q   <= 1'b1;
          state   <= WR;
        end

        WR: begin
          if (mem.gnt) begin
            req_q  <= 1'b0;
            wren_q <= 1'b0;
            state  <= NEXT;
          end
        end

        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE) && (state != FINISH);
  assign done      = (state == FINISH);
  assign mem.req   = req_q;
  assign mem.wren  = wren_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

endmodule
